// File: rtl/phy_pkg.sv
// Shared receive-PHY definitions: comma symbol, lane count and the alignment FSM states.
package phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int         LANES   = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_byte_aligner.sv
// Serial-to-byte front end: hunts for COM on any bit, confirms BC_NEEDED spaced COMs,
// then strobes one byte per 8 bits forever (no realignment once active).
module serial_byte_aligner
  import phy_pkg::*;
#(
  parameter int BC_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] byte_now,
  output logic       byte_stb,
  output logic       lock_stb,
  output logic       active
);

  rx_state_e  r_state;
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic       w_is_com;
  logic       w_boundary;

  assign byte_now   = {r_sr, data_in};
  assign w_is_com   = (byte_now == COM_SYM);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign byte_stb   = (r_state == ACTIVE) && w_boundary;
  assign active     = (r_state == ACTIVE);

  // Combinational so the top can raise idle on the very edge the lock happens.
  always_comb begin
    lock_stb = 1'b0;
    case (r_state)
      SEARCH:  lock_stb = w_is_com && (BC_NEEDED == 1);
      ALIGN:   lock_stb = w_boundary && w_is_com && ((r_com_cnt + 4'd1) == 4'(BC_NEEDED));
      default: lock_stb = 1'b0;
    endcase
  end

  always_ff @(posedge clk_32f or negedge rst) begin
    if (!rst) begin
      r_state   <= SEARCH;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_com_cnt <= '0;
    end else begin
      r_sr      <= byte_now[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      case (r_state)
        SEARCH: begin
          if (w_is_com) begin
            r_bit_cnt <= '0;
            r_com_cnt <= 4'd1;
            r_state   <= lock_stb ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          if (w_boundary) begin
            if (!w_is_com) begin
              r_state   <= SEARCH;
              r_com_cnt <= '0;
            end else begin
              r_com_cnt <= r_com_cnt + 4'd1;
              if (lock_stb) r_state <= ACTIVE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_serial_unstriper.sv
// Receive unstriper: aligned bytes are dealt round-robin onto 4 lanes and published
// as a whole word on the lane-3 byte; COM bytes mark idle and abort partial words.
module rx_serial_unstriper
  import phy_pkg::*;
#(
  parameter int BC_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       active,
  output logic       idle_out,
  output logic       err_partial
);

  localparam int PTR_W = $clog2(LANES);

  logic [7:0]                  w_byte;
  logic                        w_stb;
  logic                        w_lock;
  logic [PTR_W-1:0]            r_ptr;
  logic [LANES-2:0][7:0]       r_lane;
  logic [LANES-1:0][7:0]       r_out;
  logic                        r_valid;
  logic                        r_idle;
  logic                        r_err;

  serial_byte_aligner #(.BC_NEEDED(BC_NEEDED)) u_align (
    .clk_32f  (clk_32f),
    .rst      (rst),
    .data_in  (data_in),
    .byte_now (w_byte),
    .byte_stb (w_stb),
    .lock_stb (w_lock),
    .active   (active)
  );

  always_ff @(posedge clk_32f or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_lane  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_lock) begin
      r_idle <= 1'b1;
    end else if (w_stb) begin
      if (w_byte == COM_SYM) begin
        r_idle  <= 1'b1;
        r_valid <= 1'b0;
        r_ptr   <= '0;
        if (r_ptr != '0) r_err <= 1'b1;
      end else begin
        r_idle <= 1'b0;
        // Last lane byte goes straight to the output alongside the held lanes.
        if (r_ptr == PTR_W'(LANES-1)) begin
          r_out   <= {r_lane[0], r_lane[1], r_lane[2], w_byte};
          r_valid <= 1'b1;
          r_ptr   <= '0;
        end else begin
          r_lane[r_ptr] <= w_byte;
          r_ptr         <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign out0        = r_out[3];
  assign out1        = r_out[2];
  assign out2        = r_out[1];
  assign out3        = r_out[0];
  assign valid_out0  = r_valid;
  assign valid_out1  = r_valid;
  assign valid_out2  = r_valid;
  assign valid_out3  = r_valid;
  assign idle_out    = r_idle;
  assign err_partial = r_err;

endmodule

// File: tb/tb_rx_serial_unstriper.sv
// Bench for rx_serial_unstriper: directed byte table, hand corner sequences, and
// random streams checked bit-by-bit against a queue-based reference model.
module tb_rx_serial_unstriper;

  localparam int         BCN = 4;
  localparam logic [7:0] COM = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       rst;
  logic       data_in;
  logic [7:0] out0, out1, out2, out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       active, idle_out, err_partial;

  int n_cmp = 0;
  int n_bad = 0;

  rx_serial_unstriper #(.BC_NEEDED(BCN)) dut (
    .clk_32f(clk_32f), .rst(rst), .data_in(data_in),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .valid_out2(valid_out2), .valid_out3(valid_out3),
    .active(active), .idle_out(idle_out), .err_partial(err_partial)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model (byte/queue level) ----------------
  int         m_t, m_cand, m_lockt;
  logic [7:0] m_win;
  logic       m_lock, m_idle, m_err;
  logic [3:0] m_vld;
  logic [31:0] m_outs;
  logic [7:0] m_q[$];

  task automatic model_reset();
    m_t = 0; m_cand = -1; m_lockt = 0; m_win = '0;
    m_lock = 0; m_idle = 0; m_err = 0; m_vld = '0; m_outs = '0;
    m_q.delete();
  endtask

  task automatic model_bit(input logic b);
    m_t++;
    m_win = {m_win[6:0], b};
    if (!m_lock) begin
      if (m_cand < 0) begin
        if (m_win == COM) begin
          m_cand = m_t;
          if (BCN == 1) begin m_lock = 1; m_lockt = m_t; m_idle = 1; end
        end
      end else if ((m_t - m_cand) % 8 == 0) begin
        if (m_win != COM) m_cand = -1;
        else if ((m_t - m_cand) / 8 + 1 == BCN) begin
          m_lock = 1; m_lockt = m_t; m_idle = 1;
        end
      end
    end else if ((m_t - m_lockt) % 8 == 0) begin
      if (m_win == COM) begin
        m_idle = 1; m_vld = '0;
        if (m_q.size() != 0) m_err = 1;
        m_q.delete();
      end else begin
        m_idle = 0;
        m_q.push_back(m_win);
        if (m_q.size() == 4) begin
          m_outs = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_vld  = 4'hF;
          m_q.delete();
        end
      end
    end
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic chk(input string nm, input logic ea, input logic ei, input logic ee,
                     input logic [3:0] ev, input logic [31:0] eo);
    logic [3:0]  v;
    logic [31:0] o;
    v = {valid_out0, valid_out1, valid_out2, valid_out3};
    o = {out0, out1, out2, out3};
    n_cmp++;
    if ({active, idle_out, err_partial, v, o} !== {ea, ei, ee, ev, eo}) begin
      n_bad++;
      $display("FAIL %s: got act=%b idle=%b err=%b vld=%b outs=%h, want act=%b idle=%b err=%b vld=%b outs=%h",
               nm, active, idle_out, err_partial, v, o, ea, ei, ee, ev, eo);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  tx;
    logic        act, idle, err;
    logic [3:0]  vld;
    logic [31:0] outs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] tx, input logic a, input logic i, input logic e,
                     input logic [3:0] v, input logic [31:0] o);
    vec_t r;
    r.tx = tx; r.act = a; r.idle = i; r.err = e; r.vld = v; r.outs = o;
    tbl.push_back(r);
  endtask

  initial begin
    vec_t prev;
    logic [7:0] bq[$];
    logic [7:0] d;

    // 1: reset then idle-low line
    do_reset();
    chk("reset", 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b0);
      chk("zeros", 0, 0, 0, 4'h0, 32'h0);
    end

    // 2-5: lock, word, idle, partial word abort, recovery
    add(8'hBC, 0, 0, 0, 4'h0, 32'h0);
    add(8'hBC, 0, 0, 0, 4'h0, 32'h0);
    add(8'hBC, 0, 0, 0, 4'h0, 32'h0);
    add(8'hBC, 1, 1, 0, 4'h0, 32'h0);
    add(8'hFF, 1, 0, 0, 4'h0, 32'h0);
    add(8'hFA, 1, 0, 0, 4'h0, 32'h0);
    add(8'hBA, 1, 0, 0, 4'h0, 32'h0);
    add(8'hFF, 1, 0, 0, 4'hF, 32'hFFFABAFF);
    add(8'hBC, 1, 1, 0, 4'h0, 32'hFFFABAFF);
    add(8'hFF, 1, 0, 0, 4'h0, 32'hFFFABAFF);
    add(8'hFA, 1, 0, 0, 4'h0, 32'hFFFABAFF);
    add(8'hBC, 1, 1, 1, 4'h0, 32'hFFFABAFF);
    add(8'hFF, 1, 0, 1, 4'h0, 32'hFFFABAFF);
    add(8'hFA, 1, 0, 1, 4'h0, 32'hFFFABAFF);
    add(8'hBA, 1, 0, 1, 4'h0, 32'hFFFABAFF);
    add(8'hFF, 1, 0, 1, 4'hF, 32'hFFFABAFF);
    add(8'h11, 1, 0, 1, 4'hF, 32'hFFFABAFF);
    add(8'h22, 1, 0, 1, 4'hF, 32'hFFFABAFF);
    add(8'h33, 1, 0, 1, 4'hF, 32'hFFFABAFF);
    add(8'h44, 1, 0, 1, 4'hF, 32'h11223344);
    add(8'hBC, 1, 1, 1, 4'h0, 32'h11223344);

    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    prev.act = 0; prev.idle = 0; prev.err = 0; prev.vld = '0; prev.outs = '0;
    foreach (tbl[k]) begin
      d = tbl[k].tx;
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      chk($sformatf("tbl%0d_pre", k), prev.act, prev.idle, prev.err, prev.vld, prev.outs);
      send_bit(d[0]);
      chk($sformatf("tbl%0d", k), tbl[k].act, tbl[k].idle, tbl[k].err, tbl[k].vld, tbl[k].outs);
      prev = tbl[k];
    end

    // 6a: alignment broken by a non-COM byte falls back to search
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00); send_byte(8'hBC);
    chk("align_break", 0, 0, 0, 4'h0, 32'h0);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("relock_pending", 0, 0, 0, 4'h0, 32'h0);
    send_byte(8'hBC);
    chk("relock", 1, 1, 0, 4'h0, 32'h0);

    // 6b: async reset mid-word discards the partial word
    send_byte(8'hFF); send_byte(8'hFA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 rst = 1'b0;
    #1 chk("async_rst", 0, 0, 0, 4'h0, 32'h0);
    @(posedge clk_32f); @(posedge clk_32f);
    #1 rst = 1'b1;
    repeat (4) send_byte(8'hBC);
    chk("post_rst_lock", 1, 1, 0, 4'h0, 32'h0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("post_rst_partial", 1, 0, 0, 4'h0, 32'h0);
    send_byte(8'h44);
    chk("post_rst_word", 1, 0, 0, 4'hF, 32'h11223344);

    // random streams vs reference model
    for (int trial = 0; trial < 8; trial++) begin
      do_reset();
      bq.delete();
      repeat ($urandom_range(0, 15)) begin
        bq.push_back(8'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) begin
        bq.push_back(8'hBC);
        bq.push_back(8'($urandom_range(0, 255)) & 8'h7F);
      end
      repeat (BCN) bq.push_back(8'hBC);
      repeat (30) begin
        if ($urandom_range(0, 4) == 0) d = 8'hBC;
        else begin
          d = 8'($urandom_range(0, 255));
          if (d == 8'hBC) d = 8'h3C;
        end
        bq.push_back(d);
      end
      foreach (bq[k]) begin
        d = bq[k];
        // single junk bits are stored in bit 0 of their queue entry
        if (k < 16 && bq[k] <= 8'h01 && trial >= 0 && k < bq.size() - (BCN + 32)) begin
          send_bit(d[0]); model_bit(d[0]);
          chk("rand_bit", m_lock, m_idle, m_err, m_vld, m_outs);
        end else begin
          for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]); model_bit(d[i]);
            chk("rand", m_lock, m_idle, m_err, m_vld, m_outs);
          end
        end
      end
      if (!m_lock) begin
        n_cmp++; n_bad++;
        $display("FAIL rand_lock: model never locked in trial %0d, want lock", trial);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
